elm_hidden_ctrl: RTL

Parametrised sequencer for the ELM hidden layer. It steps an accumulator and weight LFSR through N_INPUTS samples per neuron, for N_NEURONS neurons. Neuron and input counters are internal, so no external done/stop strobes are needed. It adds an input valid/ready handshake and output backpressure, and sits between the sample source, the LFSR/accumulator datapath and the activation/output stage.

---
 rtl/elm_hidden_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/elm_hidden_ctrl.sv
// Sequencer for the ELM hidden layer: walks N_INPUTS samples per neuron for N_NEURONS neurons.
// Optional abort port is enabled by defining ELM_ABORT_EN.
module elm_hidden_ctrl #(
    parameter  int N_INPUTS  = 256,
    parameter  int N_NEURONS = 64,
    localparam int IW        = (N_INPUTS  > 1) ? $clog2(N_INPUTS)  : 1,
    localparam int NW        = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    input  logic          out_ready,
`ifdef ELM_ABORT_EN
    input  logic          abort,
`endif
    output logic          in_ready,
    output logic          acc_load,
    output logic          en_lfsr,
    output logic          acc_rst,
    output logic          rst_lfsr,
    output logic          per_load,
    output logic          out_valid,
    output logic [NW-1:0] neuron_idx,
    output logic [IW-1:0] input_idx,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETTING  = 3'd1,
        PROCESS  = 3'd2,
        LOADING  = 3'd3,
        WAIT_OUT = 3'd4,
        DONE     = 3'd5
    } state_t;

    localparam logic [IW-1:0] LAST_IN  = IW'(N_INPUTS - 1);
    localparam logic [NW-1:0] LAST_NRN = NW'(N_NEURONS - 1);

    state_t          state_q, state_d;
    logic [IW-1:0]   in_idx_q, in_idx_d;
    logic [NW-1:0]   nrn_idx_q, nrn_idx_d;
    logic            hs;

    assign hs = in_valid & in_ready;

    // NOTE: reset is synchronous here, so it lives inside the clocked branch, not the sensitivity list.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            in_idx_q  <= '0;
            nrn_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            in_idx_q  <= in_idx_d;
            nrn_idx_q <= nrn_idx_d;
        end
    end

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        in_idx_d  = in_idx_q;
        nrn_idx_d = nrn_idx_q;
        case (state_q)
            IDLE, DONE: begin
                in_idx_d  = '0;
                nrn_idx_d = '0;
                if (start) state_d = SETTING;
            end
            SETTING: begin
                in_idx_d  = '0;
                nrn_idx_d = '0;
                state_d   = PROCESS;
            end
            PROCESS: begin
                if (hs) begin
                    if (in_idx_q == LAST_IN) begin
                        in_idx_d = '0;
                        state_d  = LOADING;
                    end else begin
                        in_idx_d = in_idx_q + IW'(1);
                    end
                end
            end
            LOADING: state_d = WAIT_OUT;
            WAIT_OUT: begin
                if (out_ready) begin
                    if (nrn_idx_q == LAST_NRN) begin
                        nrn_idx_d = '0;
                        state_d   = DONE;
                    end else begin
                        nrn_idx_d = nrn_idx_q + NW'(1);
                        state_d   = PROCESS;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                in_idx_d  = '0;
                nrn_idx_d = '0;
            end
        endcase
`ifdef ELM_ABORT_EN
        // Abort ranks just below rst and discards the run in progress.
        if (abort && (state_q != IDLE)) begin
            state_d   = IDLE;
            in_idx_d  = '0;
            nrn_idx_d = '0;
        end
`endif
    end

    always_comb begin
        in_ready  = 1'b0;
        acc_rst   = 1'b0;
        rst_lfsr  = 1'b0;
        per_load  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            SETTING: begin
                acc_rst = 1'b1;
                busy    = 1'b1;
            end
            PROCESS: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            LOADING: begin
                per_load = 1'b1;
                busy     = 1'b1;
            end
            WAIT_OUT: begin
                out_valid = 1'b1;
                acc_rst   = 1'b1;
                busy      = 1'b1;
            end
            DONE: begin
                done     = 1'b1;
                rst_lfsr = 1'b1;
                acc_rst  = 1'b1;
            end
            default: begin
                rst_lfsr = 1'b1;
                acc_rst  = 1'b1;
            end
        endcase
    end

    // Accumulate and LFSR advance are the only outputs that follow the live handshake.
    assign acc_load   = hs;
    assign en_lfsr    = hs;
    assign neuron_idx = nrn_idx_q;
    assign input_idx  = in_idx_q;

endmodule
